blc_stats_roi: RTL and testbench

Parametrised black-level statistics block for the ISP front end. It watches a raw AXI4-Stream with CH pixel lanes per beat and accumulates per-lane sums over a programmable optical-black window, across FRAMES frames. A shared sequential divider then produces rounded per-lane black-level offsets with a valid strobe. It sits in parallel with the BLC correction stage and feeds that stage's offset registers.

---
 rtl/blc_stats_roi.sv | 184 ++++++++++++++++++
 tb/tb_blc_stats_roi.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/blc_stats_roi.sv
// blc_stats_roi: per-lane black-level sums over an ROI across FRAMES frames,
// followed by a shared restoring divider that yields rounded per-lane means.
module blc_stats_roi #(
    parameter int CH     = 4,
    parameter int PW     = 10,
    parameter int FRAMES = 30,
    parameter int XW     = 12
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    input  logic [CH*PW-1:0] I_tdata,
    input  logic             I_tvalid,
    input  logic             I_tuser,
    input  logic             I_tlast,
    output logic             I_tready,
    input  logic             I_enable,
    input  logic             I_clr,
    input  logic [XW-1:0]    I_roi_x0,
    input  logic [XW-1:0]    I_roi_x1,
    input  logic [XW-1:0]    I_roi_y0,
    input  logic [XW-1:0]    I_roi_y1,
    output logic [CH*PW-1:0] O_offset,
    output logic             O_valid,
    output logic [31:0]      O_count,
    output logic             O_busy,
    output logic             O_err_empty,
    output logic             O_err_overrun,
    output logic             O_err_sat
);
    localparam int ACC_W = PW + 32;
    localparam int DW    = ACC_W + 2;
    localparam int RW    = DW - PW;
    localparam int LW    = CH > 1 ? $clog2(CH) : 1;
    localparam int BW    = $clog2(PW);

    typedef enum logic {S_IDLE, S_ACCUM} state_t;
    typedef enum logic [1:0] {D_LOAD, D_RUN, D_OUT} dstate_t;

    state_t           state_q, state_d;
    dstate_t          dst;
    logic [XW-1:0]    x_q, y_q, x_e, y_e;
    logic [7:0]       frm_q;
    logic [ACC_W-1:0] acc   [CH];
    logic [ACC_W-1:0] sum_s [CH];
    logic [DW-1:0]    dvd   [CH];
    logic [31:0]      cnt_q, cnt_s;
    logic [RW-1:0]    r;
    logic [RW:0]      dv, t;
    logic [PW-1:0]    sh;
    logic [CH*PW-1:0] q;
    logic [LW-1:0]    ln, ln_n;
    logic [BW-1:0]    bc;
    logic             sof, roi, add, close, restart, free, take, ge;
    logic             empty_ev, over_ev, sat_ev;

    assign I_tready = 1'b1;
    assign x_e      = I_tuser ? '0 : x_q;
    assign y_e      = I_tuser ? '0 : y_q;
    assign sof      = I_tvalid & I_tuser;
    assign roi      = I_tvalid && x_e >= I_roi_x0 && x_e <= I_roi_x1 && y_e >= I_roi_y0 && y_e <= I_roi_y1;
    assign add      = roi && cnt_q != '1;
    // The output cycle can accept a new snapshot since the old result leaves that edge
    assign free     = !O_busy || dst == D_OUT;
    assign take     = close && cnt_q != '0 && free;
    assign empty_ev = close && cnt_q == '0;
    assign over_ev  = close && cnt_q != '0 && !free;
    assign sat_ev   = state_d == S_ACCUM && !restart && add && cnt_q == 32'hFFFF_FFFE;
    assign t        = {r, sh[PW-1]};
    assign ge       = t >= dv;
    assign ln_n     = ln + LW'(1);

    always_comb begin
        state_d = !I_enable ? S_IDLE : (state_q == S_IDLE && sof) ? S_ACCUM : state_q;
        close   = I_enable && state_q == S_ACCUM && sof && frm_q == 8'(FRAMES - 1);
        restart = state_d == S_ACCUM && (state_q == S_IDLE || close);
    end

    // Rounded mean: (2*sum + count) / (2*count)
    always_comb begin
        for (int k = 0; k < CH; k++) dvd[k] = {1'b0, sum_s[k], 1'b0} + DW'(cnt_s);
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            frm_q   <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < CH; k++) acc[k] <= '0;
        end else begin
            state_q <= state_d;
            if (I_tvalid) begin
                x_q <= I_tlast ? '0 : x_e + XW'(1);
                y_q <= I_tlast ? y_e + XW'(1) : y_e;
            end
            if (state_d == S_IDLE) begin
                frm_q <= '0;
                cnt_q <= '0;
                for (int k = 0; k < CH; k++) acc[k] <= '0;
            end else if (restart) begin
                frm_q <= '0;
                cnt_q <= 32'(roi);
                for (int k = 0; k < CH; k++) acc[k] <= roi ? ACC_W'(I_tdata[k*PW +: PW]) : '0;
            end else begin
                if (sof) frm_q <= frm_q + 8'd1;
                if (add) begin
                    cnt_q <= cnt_q + 32'd1;
                    for (int k = 0; k < CH; k++) acc[k] <= acc[k] + ACC_W'(I_tdata[k*PW +: PW]);
                end
            end
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_offset <= '0;
            O_count  <= '0;
            O_valid  <= 1'b0;
            O_busy   <= 1'b0;
            dst      <= D_LOAD;
            cnt_s    <= '0;
            r        <= '0;
            sh       <= '0;
            q        <= '0;
            dv       <= '0;
            ln       <= '0;
            bc       <= '0;
            for (int k = 0; k < CH; k++) sum_s[k] <= '0;
        end else begin
            O_valid <= 1'b0;
            if (O_busy) begin
                case (dst)
                    D_LOAD: begin
                        dv  <= {2'b0, cnt_s, 1'b0};
                        r   <= dvd[0][DW-1:PW];
                        sh  <= dvd[0][PW-1:0];
                        ln  <= '0;
                        bc  <= '0;
                        dst <= D_RUN;
                    end
                    D_RUN: begin
                        if (bc == BW'(PW - 1)) begin
                            q[ln*PW +: PW] <= {sh[PW-2:0], ge};
                            ln  <= ln_n;
                            bc  <= '0;
                            r   <= dvd[ln_n][DW-1:PW];
                            sh  <= dvd[ln_n][PW-1:0];
                            dst <= ln == LW'(CH - 1) ? D_OUT : D_RUN;
                        end else begin
                            r  <= ge ? RW'(t - dv) : t[RW-1:0];
                            sh <= {sh[PW-2:0], ge};
                            bc <= bc + BW'(1);
                        end
                    end
                    default: begin
                        O_offset <= q;
                        O_count  <= cnt_s;
                        O_valid  <= 1'b1;
                        O_busy   <= 1'b0;
                    end
                endcase
            end
            if (take) begin
                for (int k = 0; k < CH; k++) sum_s[k] <= acc[k];
                cnt_s  <= cnt_q;
                O_busy <= 1'b1;
                dst    <= D_LOAD;
            end
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_err_empty   <= 1'b0;
            O_err_overrun <= 1'b0;
            O_err_sat     <= 1'b0;
        end else begin
            O_err_empty   <= empty_ev | (O_err_empty & ~I_clr);
            O_err_overrun <= over_ev | (O_err_overrun & ~I_clr);
            O_err_sat     <= sat_ev | (O_err_sat & ~I_clr);
        end
    end
endmodule

// File: tb/tb_blc_stats_roi.sv
// tb_blc_stats_roi: randomized and directed stimulus checked against a
// window-level arithmetic model of the black-level statistics.
module tb_blc_stats_roi;
    localparam int CH  = 4;
    localparam int PW  = 10;
    localparam int FR  = 2;
    localparam int XW  = 12;
    localparam int LAT = CH * PW + 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CH*PW-1:0] tdata = '0;
    logic             tvalid = 1'b0, tuser = 1'b0, tlast = 1'b0;
    logic             tready;
    logic             en = 1'b0, clr = 1'b0;
    logic [XW-1:0]    x0 = 0, x1 = 1, y0 = 0, y1 = 1;
    logic [CH*PW-1:0] O_offset;
    logic             O_valid, O_busy, O_err_empty, O_err_overrun, O_err_sat;
    logic [31:0]      O_count;

    blc_stats_roi #(.CH(CH), .PW(PW), .FRAMES(FR), .XW(XW)) dut (
        .I_clk(clk), .I_rst_n(rst_n), .I_tdata(tdata), .I_tvalid(tvalid),
        .I_tuser(tuser), .I_tlast(tlast), .I_tready(tready), .I_enable(en),
        .I_clr(clr), .I_roi_x0(x0), .I_roi_x1(x1), .I_roi_y0(y0), .I_roi_y1(y1),
        .O_offset(O_offset), .O_valid(O_valid), .O_count(O_count), .O_busy(O_busy),
        .O_err_empty(O_err_empty), .O_err_overrun(O_err_overrun), .O_err_sat(O_err_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH*PW-1:0] off;
        longint           cnt;
        longint           due;
    } exp_t;

    int               errs = 0, checks = 0;
    longint           cyc = 0;
    exp_t             expq[$];
    bit               act = 0, e_empty = 0, e_over = 0;
    int               frm = 0;
    longint           msum[CH];
    longint           mcnt = 0, busy_end = 0;
    logic [CH*PW-1:0] last_off = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wipe();
        for (int k = 0; k < CH; k++) msum[k] = 0;
        mcnt = 0;
    endtask

    task automatic model_reset();
        act = 0;
        frm = 0;
        wipe();
        expq.delete();
        busy_end = 0;
        e_empty = 0;
        e_over = 0;
    endtask

    task automatic close_win(input longint now);
        exp_t e;
        if (mcnt == 0) e_empty = 1;
        else if (now < busy_end) e_over = 1;
        else begin
            for (int k = 0; k < CH; k++) e.off[k*PW +: PW] = PW'((2 * msum[k] + mcnt) / (2 * mcnt));
            e.cnt = mcnt;
            e.due = now + LAT;
            busy_end = now + LAT;
            expq.push_back(e);
            chk("busy_rise", O_busy, 1);
        end
    endtask

    // One clock of stimulus; the model advances with the same edge
    task automatic step(input logic [CH*PW-1:0] d, input bit v, u, l, input int xx, yy);
        bit roi, cl;
        tdata = d;
        tvalid = v;
        tuser = u;
        tlast = l;
        roi = v && xx >= int'(x0) && xx <= int'(x1) && yy >= int'(y0) && yy <= int'(y1);
        @(posedge clk);
        #1;
        cl = 0;
        if (clr) begin
            e_empty = 0;
            e_over = 0;
        end
        if (!en) act = 0;
        else if (!act) begin
            if (v && u) begin
                act = 1;
                frm = 0;
                wipe();
            end
        end else if (v && u) begin
            if (frm == FR - 1) cl = 1;
            else frm++;
        end
        if (cl) begin
            close_win(cyc);
            wipe();
            frm = 0;
        end
        if (act && roi) begin
            for (int k = 0; k < CH; k++) msum[k] += longint'(d[k*PW +: PW]);
            mcnt++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step('0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [CH*PW-1:0] pix(input int mode, xx, yy);
        logic [CH*PW-1:0] d;
        for (int k = 0; k < CH; k++) begin
            case (mode)
                0: d[k*PW +: PW] = PW'(64 + k);
                1: d[k*PW +: PW] = k == 0 ? PW'(10 + (xx & 1)) : k == 1 ? PW'(((xx & yy & 1) != 0) ? 11 : 10) : PW'(10 * k);
                2: d[k*PW +: PW] = PW'($urandom_range(0, 1023));
                default: d[k*PW +: PW] = '1;
            endcase
        end
        return d;
    endfunction

    task automatic frame(input int lines, beats, mode, gap);
        for (int yy = 0; yy < lines; yy++)
            for (int xx = 0; xx < beats; xx++) begin
                while (gap > 0 && $urandom_range(0, 99) < gap) step(pix(2, 0, 0), 0, 0, 0, 0, 0);
                step(pix(mode, xx, yy), 1, xx == 0 && yy == 0, xx == beats - 1, xx, yy);
            end
    endtask

    task automatic run(input int mode, lines, beats, nf, gap);
        en = 0;
        idle(1);
        en = 1;
        repeat (nf) frame(lines, beats, mode, gap);
        idle(50);
    endtask

    task automatic pulse_clr();
        clr = 1;
        idle(1);
        clr = 0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && O_valid) begin
            if (expq.size() == 0) chk("spurious_valid", 1, 0);
            else begin
                e = expq.pop_front();
                chk("offset", O_offset, e.off);
                chk("count", O_count, e.cnt);
                chk("latency", cyc, e.due);
                last_off = e.off;
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_offset", O_offset, 0);
        chk("rst_count", O_count, 0);
        chk("rst_valid", O_valid, 0);
        chk("rst_busy", O_busy, 0);
        chk("rst_empty", O_err_empty, 0);
        chk("rst_over", O_err_overrun, 0);
        chk("rst_sat", O_err_sat, 0);
        chk("tready", tready, 1);
        rst_n = 1;
        idle(2);

        run(0, 4, 8, 3, 0);
        chk("const_off", O_offset, {10'd67, 10'd66, 10'd65, 10'd64});
        chk("const_cnt", O_count, 8);

        run(1, 4, 8, 3, 0);
        chk("round_l0", O_offset[PW-1:0], 11);
        chk("round_l1", O_offset[2*PW-1:PW], 10);

        x0 = 5;
        x1 = 4;
        run(0, 4, 8, 3, 0);
        chk("empty_flag", O_err_empty, 1);
        chk("empty_keep", O_offset, last_off);
        pulse_clr();
        chk("empty_clr", O_err_empty, 0);
        x0 = 0;
        x1 = 1;

        run(0, 1, 2, 12, 0);
        chk("over_flag", O_err_overrun, 1);
        pulse_clr();
        chk("over_clr", O_err_overrun, 0);

        run(3, 4, 8, 3, 0);
        chk("sat_off", O_offset, {CH{10'd1023}});

        for (int i = 0; i < 8; i++) begin
            x0 = XW'($urandom_range(0, 5));
            x1 = XW'($urandom_range(0, 9));
            y0 = XW'($urandom_range(0, 2));
            y1 = XW'($urandom_range(0, 4));
            run(2, $urandom_range(2, 5), $urandom_range(3, 10), $urandom_range(3, 6), $urandom_range(0, 30));
        end
        chk("rand_empty", O_err_empty, e_empty);
        chk("rand_over", O_err_overrun, e_over);
        pulse_clr();
        x0 = 0; x1 = 1; y0 = 0; y1 = 1;

        en = 0;
        idle(1);
        en = 1;
        repeat (2) frame(4, 8, 0, 0);
        step(pix(0, 0, 0), 1, 1, 0, 0, 0);
        idle(10);
        chk("mid_busy", O_busy, 1);
        #3 rst_n = 0;
        #1;
        chk("arst_offset", O_offset, 0);
        chk("arst_count", O_count, 0);
        chk("arst_busy", O_busy, 0);
        chk("arst_valid", O_valid, 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
        idle(60);
        chk("arst_quiet", O_count, 0);

        en = 0;
        idle(1);
        en = 1;
        repeat (2) frame(4, 8, 1, 0);
        step(pix(0, 0, 0), 1, 1, 0, 0, 0);
        for (int xx = 1; xx < 4; xx++) step(pix(0, xx, 0), 1, 0, 0, xx, 0);
        en = 0;
        repeat (2) frame(4, 8, 0, 0);
        idle(50);
        chk("drop_busy", O_busy, 0);
        chk("drop_l0", O_offset[PW-1:0], 11);

        chk("pending", expq.size(), 0);
        chk("final_empty", O_err_empty, e_empty);
        chk("final_over", O_err_overrun, e_over);
        chk("final_sat", O_err_sat, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
